// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter: round-robin, burst-locked sharing of one FIFO enqueue port
module fifo_enq_arbiter #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int IDW      = 2,
  parameter int MAXBURST = 8
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_bits,
  output logic [NREQ-1:0]       req_ready,
  output logic                  enq_valid,
  output logic [DSIZE+IDW-1:0]  enq_bits,
  input  logic                  enq_ready,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d, prio_q, prio_d, pick, idx;
  logic [7:0] beats_q, beats_d;
  logic found, xfer, rel;
  assign busy      = state_q == LOCKED;
  assign grant_id  = grant_q;
  assign enq_valid = busy && req_valid[grant_q];
  assign enq_bits  = {grant_q, req_bits[grant_q*DSIZE +: DSIZE]};
  assign xfer      = enq_valid && enq_ready;
  assign rel       = xfer && (req_last[grant_q] || beats_q == 8'(MAXBURST-1));
  // scan prio, prio+1, ... modulo NREQ so indices >= NREQ are never visited
  always_comb begin
    found = 1'b0;
    pick  = prio_q;
    idx   = prio_q;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(prio_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  always_comb begin
    req_ready = '0;
    req_ready[grant_q] = busy && enq_ready;
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    beats_d = beats_q;
    if (!busy && found) begin
      state_d = LOCKED;
      grant_d = pick;
      beats_d = '0;
    end
    if (xfer) beats_d = beats_q + 8'd1;
    if (rel) begin
      state_d = IDLE;
      prio_d  = IDW'((int'(grant_q) + 1) % NREQ);
    end
  end
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      prio_q  <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      beats_q <= beats_d;
    end
  end
endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// tb_fifo_enq_arbiter: vector table, directed corner sequences and random traffic vs a reference model
module tb_fifo_enq_arbiter;
  localparam int N = 4, MB = 8;
  logic wclk = 1'b0, wrst_n = 1'b1;
  logic [3:0] rv, rl, rr;
  logic [31:0] rb;
  logic er, ev, busy;
  logic [9:0] eb;
  logic [1:0] gid;
  always #5 wclk = ~wclk;

  fifo_enq_arbiter #(.NREQ(N), .DSIZE(8), .IDW(2), .MAXBURST(MB)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(rv), .req_last(rl), .req_bits(rb),
    .req_ready(rr), .enq_valid(ev), .enq_bits(eb), .enq_ready(er),
    .grant_id(gid), .busy(busy)
  );

  typedef struct {
    logic [3:0] rv, rl;
    logic er;
    logic [1:0] gid;
    logic busy, ev;
    logic [3:0] rr;
    logic [9:0] eb;
  } vec_t;
  vec_t tbl[17];

  int n_vec = 0, n_err = 0;
  int m_own, m_gid, m_prio, m_beats;
  logic [8:0] sq [4][$];
  logic [9:0] got[$];
  logic [9:0] exp_q[$];
  logic [3:0] en;
  bit use_src;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_own = -1; m_gid = 0; m_prio = 0; m_beats = 0;
  endtask

  // owner == -1 means nobody holds the port
  task automatic m_check();
    bit b;
    b = m_own >= 0;
    chk("busy", 32'(busy), 32'(b));
    chk("grant_id", 32'(gid), 32'(m_gid));
    chk("enq_valid", 32'(ev), 32'(b && rv[m_gid]));
    chk("req_ready", 32'(rr), (b && er) ? (32'd1 << m_gid) : 32'd0);
    chk("enq_bits", 32'(eb), 32'((m_gid << 8) | int'(rb[m_gid*8 +: 8])));
  endtask

  task automatic m_step();
    if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_prio + k) % N;
        if (rv[j]) begin
          m_own = j; m_gid = j; m_beats = 0;
          break;
        end
      end
    end else if (rv[m_gid] && er) begin
      m_beats++;
      if (rl[m_gid] || m_beats == MB) begin
        m_own = -1;
        m_prio = (m_gid + 1) % N;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bit has;
      has = sq[i].size() > 0;
      rv[i] = en[i] && has;
      rl[i] = has && sq[i][0][8];
      rb[i*8 +: 8] = has ? sq[i][0][7:0] : 8'h00;
    end
  endtask

  task automatic cyc();
    logic [3:0] pop;
    if (use_src) drive();
    #2;
    m_check();
    pop = rv & rr;
    if (ev && er) got.push_back(eb);
    @(posedge wclk);
    m_step();
    for (int i = 0; i < N; i++) if (pop[i]) void'(sq[i].pop_front());
    @(negedge wclk);
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    m_reset();
    for (int i = 0; i < N; i++) sq[i].delete();
    got.delete();
    exp_q.delete();
    en = 4'hF; rv = '0; rl = '0; er = 1'b1; rb = '0;
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  task automatic push_burst(int i, logic [7:0] base, int n);
    for (int b = 0; b < n; b++) sq[i].push_back({b == n-1, 8'(base + 8'(b))});
  endtask

  task automatic chk_words(string nm);
    chk({nm, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int k = 0; k < got.size() && k < exp_q.size(); k++) chk({nm, "_word"}, 32'(got[k]), 32'(exp_q[k]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 2'd0, 1'b0, 1'b0, 4'h0, 10'h011};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 2'd0, 1'b1, 1'b1, 4'h1, 10'h011};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 2'd0, 1'b0, 1'b0, 4'h0, 10'h011};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 2'd1, 1'b1, 1'b1, 4'h2, 10'h122};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 2'd1, 1'b0, 1'b0, 4'h0, 10'h122};
    tbl[5]  = '{4'hF, 4'hF, 1'b1, 2'd2, 1'b1, 1'b1, 4'h4, 10'h233};
    tbl[6]  = '{4'hF, 4'hF, 1'b1, 2'd2, 1'b0, 1'b0, 4'h0, 10'h233};
    tbl[7]  = '{4'hF, 4'hF, 1'b1, 2'd3, 1'b1, 1'b1, 4'h8, 10'h344};
    tbl[8]  = '{4'hF, 4'hF, 1'b1, 2'd3, 1'b0, 1'b0, 4'h0, 10'h344};
    tbl[9]  = '{4'hF, 4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 4'h0, 10'h011};
    tbl[10] = '{4'hF, 4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 4'h0, 10'h011};
    tbl[11] = '{4'hF, 4'hF, 1'b1, 2'd0, 1'b1, 1'b1, 4'h1, 10'h011};
    tbl[12] = '{4'h0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0, 4'h0, 10'h011};
    tbl[13] = '{4'h0, 4'h0, 1'b1, 2'd0, 1'b0, 1'b0, 4'h0, 10'h011};
    tbl[14] = '{4'h4, 4'h4, 1'b1, 2'd0, 1'b0, 1'b0, 4'h0, 10'h011};
    tbl[15] = '{4'h4, 4'h4, 1'b1, 2'd2, 1'b1, 1'b1, 4'h4, 10'h233};
    tbl[16] = '{4'h0, 4'h0, 1'b1, 2'd2, 1'b0, 1'b0, 4'h0, 10'h233};
    rb = 32'h44332211; rv = '0; rl = '0; er = 1'b1; en = 4'hF; use_src = 1'b0;
    m_reset();
    #1 wrst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_enq_valid", 32'(ev), 0);
    chk("rst_req_ready", 32'(rr), 0);
    chk("rst_grant_id", 32'(gid), 0);
    chk("rst_enq_bits", 32'(eb), 32'h011);
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int t = 0; t < 17; t++) begin
      rv = tbl[t].rv; rl = tbl[t].rl; er = tbl[t].er;
      #2;
      chk("tbl_busy", 32'(busy), 32'(tbl[t].busy));
      chk("tbl_grant_id", 32'(gid), 32'(tbl[t].gid));
      chk("tbl_enq_valid", 32'(ev), 32'(tbl[t].ev));
      chk("tbl_req_ready", 32'(rr), 32'(tbl[t].rr));
      chk("tbl_enq_bits", 32'(eb), 32'(tbl[t].eb));
      @(posedge wclk);
      @(negedge wclk);
    end
    use_src = 1'b1;

    do_reset();
    push_burst(2, 8'hA0, 5);
    push_burst(1, 8'h10, 3);
    en = 4'b0100;
    cyc();
    en = 4'b0110;
    repeat (14) cyc();
    for (int k = 0; k < 5; k++) exp_q.push_back(10'h2A0 + 10'(k));
    for (int k = 0; k < 3; k++) exp_q.push_back(10'h110 + 10'(k));
    chk_words("lock");

    do_reset();
    push_burst(0, 8'h00, 20);
    repeat (22) cyc();
    chk("cap_count22", 32'(got.size()), 19);
    cyc();
    chk("cap_count23", 32'(got.size()), 20);
    repeat (2) cyc();
    for (int k = 0; k < 20; k++) exp_q.push_back(10'(k));
    chk_words("cap");

    do_reset();
    push_burst(1, 8'h50, 6);
    repeat (3) cyc();
    er = 1'b0;
    repeat (3) cyc();
    er = 1'b1;
    repeat (6) cyc();
    for (int k = 0; k < 6; k++) exp_q.push_back(10'h150 + 10'(k));
    chk_words("bp");

    do_reset();
    push_burst(3, 8'h30, 4);
    push_burst(0, 8'h00, 2);
    en = 4'b1000;
    cyc();
    en = 4'b1001;
    repeat (2) cyc();
    en = 4'b0001;
    repeat (4) begin
      cyc();
      chk("gap_grant_id", 32'(gid), 3);
      chk("gap_enq_valid", 32'(ev), 0);
    end
    en = 4'b1001;
    repeat (8) cyc();
    for (int k = 0; k < 4; k++) exp_q.push_back(10'h330 + 10'(k));
    exp_q.push_back(10'h000);
    exp_q.push_back(10'h001);
    chk_words("gap");

    do_reset();
    push_burst(2, 8'h70, 2);
    push_burst(2, 8'h80, 10);
    repeat (5) cyc();
    chk("mid_busy", 32'(busy), 1);
    #2 wrst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_enq_valid", 32'(ev), 0);
    chk("mid_rst_req_ready", 32'(rr), 0);
    chk("mid_rst_grant_id", 32'(gid), 0);
    chk("mid_rst_enq_bits", 32'(eb), 32'(rb[7:0]));
    m_reset();
    for (int i = 0; i < N; i++) sq[i].delete();
    got.delete();
    @(negedge wclk);
    wrst_n = 1'b1;
    push_burst(1, 8'h91, 1);
    push_burst(3, 8'h93, 1);
    repeat (5) cyc();
    exp_q.push_back(10'h191);
    exp_q.push_back(10'h393);
    chk_words("post_rst");

    do_reset();
    repeat (800) begin
      for (int i = 0; i < N; i++)
        if (sq[i].size() < 3 && $urandom_range(3) == 0) push_burst(i, 8'($urandom), int'($urandom_range(1, 12)));
      en = 4'($urandom);
      er = $urandom_range(3) != 0;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_enq_arbiter.md
# fifo_enq_arbiter

Write-clock-domain arbiter that shares the single enqueue port of the team's dual-clock FIFO between `NREQ` requesters. It grants the port to one requester at a time using round-robin priority and holds the grant for a whole burst. A burst ends on `req_last`, or when `MAXBURST` beats have been transferred. Each enqueued word carries the source ID in its upper bits, so the read domain can demultiplex. The block sits directly in front of the FIFO's `enq_valid`/`enq_bits`/`enq_ready` and runs on the FIFO's write clock.

## Interface
Parameters:
- `NREQ`, 4 — number of requesters (2..16).
- `DSIZE`, 8 — payload width per requester.
- `IDW`, 2 — source-ID width; must satisfy 2^IDW ≥ NREQ.
- `MAXBURST`, 8 — maximum beats per grant (1..255).

Ports:
- `wclk` in 1 — write-domain clock.
- `wrst_n` in 1 — reset, asynchronous, active-low.
- `req_valid` in NREQ — per-requester data valid.
- `req_last` in NREQ — per-requester last beat of burst.
- `req_bits` in NREQ*DSIZE — payloads; requester i occupies bits [i*DSIZE +: DSIZE].
- `req_ready` out NREQ — per-requester accept.
- `enq_valid` out 1 — to FIFO enq_valid.
- `enq_bits` out DSIZE+IDW — to FIFO enq_bits, formatted {grant_id, payload}.
- `enq_ready` in 1 — from FIFO enq_ready (not-full).
- `grant_id` out IDW — currently granted requester; registered.
- `busy` out 1 — high while in LOCKED.

## Operation
- The FSM has two states: IDLE and LOCKED. Registered state:
  - FSM state
  - `grant_id`
  - round-robin pointer `prio` (IDW bits)
  - beat counter `beats` (8 bits)
- **IDLE:**
  - `enq_valid`=0 and `req_ready`=0.
  - If any `req_valid` is high, select the first asserted index scanning `prio`, `prio`+1, …, wrapping modulo NREQ.
  - Register that index into `grant_id`, clear `beats`, and go to LOCKED.
- **LOCKED:**
  - `enq_valid` = `req_valid[grant_id]`.
  - `req_ready[grant_id]` = `enq_ready`; all other `req_ready` bits are 0.
  - `enq_bits` = {`grant_id`, `req_bits[grant_id]`}.
- **Beat transfer:** a beat transfers when `enq_valid` && `enq_ready`. On each transfer, `beats` increments.
- **Release:** on a transfer where `req_last[grant_id]`=1 or `beats`==MAXBURST-1:
  - go to IDLE;
  - set `prio` = (`grant_id`+1) mod NREQ.
- **Requester drops valid mid-burst:** the grant is held. There is no timeout and no re-arbitration.
- **FIFO full:** with `enq_ready`=0 no transfer occurs; `beats` and state hold.
- **MAXBURST cap:** release without `req_last` is legal. The requester's remaining beats compete again later as a new burst.
- **Combinational paths:** `enq_valid` must never depend combinationally on `enq_ready`. `req_ready` may depend on `enq_ready`, since the FIFO's not-full flag is registered.
- **Out-of-range indices:** indices ≥ NREQ never win arbitration.

## Timing
- **Reset values:**
  - state = IDLE
  - `grant_id` = 0
  - `prio` = 0
  - `beats` = 0
  - `busy` = 0
  - `enq_valid` = 0
  - `req_ready` = 0
  - `enq_bits` = {0, `req_bits[0]`}
- **Grant latency:** a request seen in IDLE at edge N is granted at edge N+1. The first beat can transfer in the cycle following edge N+1.
- **Throughput:**
  - A B-beat burst with continuous valid/ready occupies B+1 cycles (1 arbitration bubble).
  - Back-to-back bursts from different requesters have exactly 1 idle cycle between them.
- **Release timing:** `busy` falls on the edge that captures the releasing transfer. The requester's `req_ready` deasserts in the same cycle.
- **Reset mid-burst:** an asynchronous return to reset values. Any beat not yet accepted is not written. A partially written burst remains in the FIFO.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,…,NREQ-1, and each requester waits at most (NREQ-1)*(MAXBURST+1) cycles.

## Test plan
- **Round-robin order:** reset; all 4 `req_valid`=1, `req_last`=1 every beat, `enq_ready`=1 → `grant_id` sequence 0,1,2,3,0; one enq per 2 cycles; `enq_bits`[9:8] match `grant_id`.
- **Burst lock:**
  - Stimulus: requester 2 sends 5 beats 0xA0..0xA4 with last on 0xA4; requester 1 is valid throughout.
  - Required response: the 5 words are enqueued contiguously as 0x2A0..0x2A4; then requester 1 is granted.
- **MAXBURST cap:** MAXBURST=8; requester 0 streams 20 beats with no last → release after 8 beats; if others are idle, regrant to 0 after 1 bubble; chunks of 8, 8, 4 (last on beat 20).
- **FIFO backpressure:** `enq_ready`=0 for 3 cycles mid-burst → `req_ready` low, no beat lost or duplicated, `beats` unchanged.
- **Valid gap:** granted requester 3 deasserts valid for 4 cycles mid-burst while requester 0 is valid → `enq_valid`=0 and `grant_id` stays 3 throughout the gap.
- **Reset mid-burst:** assert `wrst_n` low asynchronously while `busy`=1 → all outputs at reset values immediately; after release, next grant starts from `prio`=0.
